// File: rtl/calc_mem_ctrl_pkg.sv
// Shared types and constants for the memory-backed calculator.
// Operation codes, controller states and default word addresses.
package calc_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    AND = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    LAT_A,
    RD_B,
    LAT_B,
    EXEC,
    WR,
    DONE
  } state_e;

  localparam logic [1:0] DEF_ADDR_A = 2'd0;
  localparam logic [1:0] DEF_ADDR_B = 2'd1;
  localparam logic [1:0] DEF_ADDR_R = 2'd2;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  function automatic logic [15:0] sat16(
    input logic neg
  );
    return neg ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/calc_mem_ctrl_if.sv
// Synchronous single-port memory bus between controller and memory.
// Read data arrives one cycle after the address (registered read).
interface calc_mem_if;

  logic        cs;
  logic        we;
  logic        oe;
  logic [1:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_rdata;

  modport master (
    output cs,
    output we,
    output oe,
    output mem_addr,
    output mem_data,
    input  mem_rdata
  );

  modport slave (
    input  cs,
    input  we,
    input  oe,
    input  mem_addr,
    input  mem_data,
    output mem_rdata
  );

endinterface

// File: rtl/calc_mem_ctrl_alu.sv
// Combinational 16-bit signed ALU: add, sub, mul, and.
// Define CALC_SAT_EN to saturate overflowing add/sub/mul results.
module calc_alu
  import calc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  op_e         op,
  output logic [15:0] y,
  output logic        ovf
);

  logic [16:0]        sum;
  logic [16:0]        dif;
  logic signed [31:0] prod;

  always_comb begin
    sum  = {a[15], a} + {b[15], b};
    dif  = {a[15], a} - {b[15], b};
    prod = $signed(a) * $signed(b);
    y    = 16'h0000;
    ovf  = 1'b0;
    unique case (op)
      ADD: begin
        y   = sum[15:0];
        ovf = sum[16] ^ sum[15];
      end
      SUB: begin
        y   = dif[15:0];
        ovf = dif[16] ^ dif[15];
      end
      MUL: begin
        y   = prod[15:0];
        ovf = !((&prod[31:15]) || !(|prod[31:15]));
      end
      AND: begin
        y   = a & b;
        ovf = 1'b0;
      end
    endcase
`ifdef CALC_SAT_EN
    // Sign of the true result: bit 16 for add/sub, bit 31 for mul.
    if (ovf) begin
      unique case (op)
        ADD:     y = sat16(sum[16]);
        SUB:     y = sat16(dif[16]);
        MUL:     y = sat16(prod[31]);
        default: y = a & b;
      endcase
    end
`else
`endif
  end

endmodule

// File: rtl/calc_mem_ctrl.sv
// Calculator that reads two operands from memory and writes back the result.
// Optional saturation of overflowing results via macro CALC_SAT_EN.
module calc_mem_ctrl
  import calc_pkg::*;
#(
  parameter logic [1:0] ADDR_A = DEF_ADDR_A,
  parameter logic [1:0] ADDR_B = DEF_ADDR_B,
  parameter logic [1:0] ADDR_R = DEF_ADDR_R
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  calc_mem_if.master  mem
);

  state_e      state_q;
  state_e      state_d;
  op_e         op_q;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] alu_y;
  logic        alu_ovf;

  calc_alu u_alu (
    .a   (op_a),
    .b   (op_b),
    .op  (op_q),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= ADD;
      op_a   <= 16'h0000;
      op_b   <= 16'h0000;
      result <= 16'h0000;
      ovf    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) op_q <= op_e'(op);
      if (state_q == LAT_A) op_a <= mem.mem_rdata;
      if (state_q == LAT_B) op_b <= mem.mem_rdata;
      if (state_q == EXEC) begin
        result <= alu_y;
        ovf    <= alu_ovf;
      end
    end
  end

  // Bus strobes decode from state alone, so reset clears them at once.
  always_comb begin
    state_d      = state_q;
    busy         = 1'b1;
    done         = 1'b0;
    mem.cs       = 1'b0;
    mem.we       = 1'b0;
    mem.oe       = 1'b0;
    mem.mem_addr = 2'd0;
    mem.mem_data = 16'h0000;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RD_A;
      end
      RD_A: begin
        mem.cs       = 1'b1;
        mem.mem_addr = ADDR_A;
        state_d      = LAT_A;
      end
      LAT_A: begin
        mem.cs       = 1'b1;
        mem.oe       = 1'b1;
        mem.mem_addr = ADDR_A;
        state_d      = RD_B;
      end
      RD_B: begin
        mem.cs       = 1'b1;
        mem.mem_addr = ADDR_B;
        state_d      = LAT_B;
      end
      LAT_B: begin
        mem.cs       = 1'b1;
        mem.oe       = 1'b1;
        mem.mem_addr = ADDR_B;
        state_d      = EXEC;
      end
      EXEC: begin
        state_d = WR;
      end
      WR: begin
        mem.cs       = 1'b1;
        mem.we       = 1'b1;
        mem.mem_addr = ADDR_R;
        mem.mem_data = result;
        state_d      = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_mem_ctrl.sv
// Self-checking bench for calc_mem_ctrl with a registered-read memory model.
// Expected results depend on CALC_SAT_EN, matching the RTL build.
module tb_calc_mem_ctrl;
  import calc_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] y;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
  } exp_t;

`ifdef CALC_SAT_EN
  localparam logic [15:0] Y_SUB_OVF = 16'h8000;
  localparam logic [15:0] Y_MUL_OVF = 16'h7FFF;
  localparam logic [15:0] Y_ADD_POS = 16'h7FFF;
  localparam logic [15:0] Y_MUL_SQ  = 16'h7FFF;
  localparam logic [15:0] Y_ADD_NEG = 16'h8000;
`else
  localparam logic [15:0] Y_SUB_OVF = 16'h7FFF;
  localparam logic [15:0] Y_MUL_OVF = 16'hEA60;
  localparam logic [15:0] Y_ADD_POS = 16'h8000;
  localparam logic [15:0] Y_MUL_SQ  = 16'h0000;
  localparam logic [15:0] Y_ADD_NEG = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;

  calc_mem_if mif ();

  calc_mem_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .mem    (mif)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4];
  logic [15:0] rq;
  logic        ld_en;
  logic [1:0]  ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mif.cs && mif.we) mem[mif.mem_addr] <= mif.mem_data;
    if (mif.cs && !mif.we) rq <= mem[mif.mem_addr];
  end

  assign mif.mem_rdata = mif.oe ? rq : 16'h0000;

  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    chk("we_and_oe", {31'd0, mif.we & mif.oe}, 32'd0);
    if (!busy) chk("idle_cs", {31'd0, mif.cs}, 32'd0);
    if (mif.cs && mif.we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_wr", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", {16'd0, mif.mem_data}, {16'd0, e.y});
        chk("wr_addr", {30'd0, mif.mem_addr}, {30'd0, DEF_ADDR_R});
      end
    end
    if (done) done_cnt++;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b);
    ld_en   = 1'b1;
    ld_addr = DEF_ADDR_A;
    ld_data = a;
    tick();
    ld_addr = DEF_ADDR_B;
    ld_data = b;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic run(input vec_t v, input bit ign);
    int n;
    int wr0;
    int d0;
    load(v.a, v.b);
    exp_q.push_back('{y: v.y, ovf: v.ovf});
    wr0   = wr_cnt;
    d0    = done_cnt;
    start = 1'b1;
    op    = v.op;
    tick();
    n     = 1;
    start = 1'b0;
    while (!done && n < 20) begin
      tick();
      n++;
      start = ign && n == 3;
      op    = ~v.op;
    end
    start = 1'b0;
    chk("done_lat", n, 32'd7);
    chk("result", {16'd0, result}, {16'd0, v.y});
    chk("ovf", {31'd0, ovf}, {31'd0, v.ovf});
    tick();
    chk("mem_r", {16'd0, mem[DEF_ADDR_R]}, {16'd0, v.y});
    chk("busy_end", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("n_wr", wr_cnt - wr0, 32'd1);
    chk("n_done", done_cnt - d0, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_result"}, {16'd0, result}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    chk({tag, "_bus"},
        {27'd0, mif.cs, mif.we, mif.oe, mif.mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, mif.mem_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] m2;
    vecs[0] = '{16'd5,    16'd3,    2'b00, 16'h0008,  1'b0};
    vecs[1] = '{16'h8000, 16'd1,    2'b01, Y_SUB_OVF, 1'b1};
    vecs[2] = '{16'd300,  16'd200,  2'b10, Y_MUL_OVF, 1'b1};
    vecs[3] = '{16'hF0F0, 16'h0FF0, 2'b11, 16'h00F0,  1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 2'b00, Y_ADD_POS, 1'b1};
    vecs[5] = '{16'hFFFE, 16'h0003, 2'b10, 16'hFFFA,  1'b0};
    vecs[6] = '{16'h0003, 16'h0005, 2'b01, 16'hFFFE,  1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 2'b10, Y_MUL_SQ,  1'b1};
    vecs[8] = '{16'h8000, 16'h8000, 2'b00, Y_ADD_NEG, 1'b1};

    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    ld_en   = 1'b0;
    ld_addr = 2'd0;
    ld_data = 16'h0000;
    #1;
    chk_zero("reset");
    for (int i = 0; i < 4; i++) begin
      ld_en   = 1'b1;
      ld_addr = i[1:0];
      ld_data = 16'h0000;
      tick();
    end
    ld_en = 1'b0;
    rst   = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run(vecs[i], 1'b0);

    run(vecs[0], 1'b1);

    load(16'h1111, 16'h2222);
    m2 = mem[DEF_ADDR_R];
    exp_q.push_back('{y: 16'h3333, ovf: 1'b0});
    start = 1'b1;
    op    = 2'b00;
    tick();
    start = 1'b0;
    n     = 1;
    while (n < 4) begin
      tick();
      n++;
    end
    chk("lat_b_bus", {29'd0, mif.oe, mif.mem_addr},
        {29'd0, 1'b1, DEF_ADDR_B});
    #2 rst = 1'b1;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    n = done_cnt;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_no_done", done_cnt - n, 32'd0);
    chk("rst_mem_r", {16'd0, mem[DEF_ADDR_R]}, {16'd0, m2});
    run('{16'h1111, 16'h2222, 2'b00, 16'h3333, 1'b0}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
